// File: rtl/match_round_ctrl.sv
// match_round_ctrl: round controller for the 4-square colour-matching game.
//   Synchronises and debounces the player button, then sequences a round:
//   pick first tile, pick second tile, show the hit or miss for a fixed time,
//   and finally show the win screen. Tracks solved tiles, attempts and win.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   btn_raw     raw player button, 1 = pressed (asynchronous to clk)
//   tile_sel    tile under the cursor, sampled on an accepted press
//   step        current state: 0 idle, 1 pick1, 2 pick2, 3 hit, 4 miss, 6 win
//   reveal      per-tile show-colour mask for the display datapath
//   matched     per-tile solved mask
//   first_tile  tile latched by the first pick
//   attempts    completed second picks, saturating
//   busy        high while a hit or miss is being displayed
//   win         high in the win state
module match_round_ctrl #(
    parameter int unsigned DB_CYCLES     = 50000,
    parameter int unsigned REVEAL_CYCLES = 25000000,
    parameter int unsigned ATTEMPT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_raw,
    input  logic [1:0]           tile_sel,
    output logic [2:0]           step,
    output logic [3:0]           reveal,
    output logic [3:0]           matched,
    output logic [1:0]           first_tile,
    output logic [ATTEMPT_W-1:0] attempts,
    output logic                 busy,
    output logic                 win
);

    localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned TMR_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;

    localparam logic [DB_W-1:0]      DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [TMR_W-1:0]     TMR_LOAD = TMR_W'(REVEAL_CYCLES - 1);
    localparam logic [ATTEMPT_W-1:0] ATT_MAX  = {ATTEMPT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK1 = 3'd1,
        ST_PICK2 = 3'd2,
        ST_HIT   = 3'd3,
        ST_MISS  = 3'd4,
        ST_WIN   = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Button path: 2-FF synchroniser, level debouncer, rising-edge pulse
    // ------------------------------------------------------------------
    logic            sync1;
    logic            sync2;
    logic            btn_state;
    logic            btn_prev;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            btn_state <= 1'b0;
            btn_prev  <= 1'b0;
            db_cnt    <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            btn_prev <= btn_state;
            // Counter only runs while the synced level disagrees with btn_state;
            // any return to agreement restarts the qualification window.
            if (sync2 != btn_state) begin
                if (db_cnt == DB_LAST) begin
                    btn_state <= sync2;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Both operands are flops, so press is a clean one-cycle pulse.
    assign press = btn_state & ~btn_prev;

    // ------------------------------------------------------------------
    // Round FSM: next-state / next-output logic
    // ------------------------------------------------------------------
    state_t                state;
    state_t                state_nxt;
    logic [3:0]            reveal_nxt;
    logic [3:0]            matched_nxt;
    logic [1:0]            first_nxt;
    logic [ATTEMPT_W-1:0]  attempts_nxt;
    logic [TMR_W-1:0]      timer;
    logic [TMR_W-1:0]      timer_nxt;
    logic                  busy_nxt;
    logic                  win_nxt;
    logic [3:0]            sel_bit;
    logic [3:0]            first_bit;
    logic                  sel_matched;

    assign sel_bit     = 4'b0001 << tile_sel;
    assign first_bit   = 4'b0001 << first_tile;
    assign sel_matched = |(matched & sel_bit);

    always_comb begin
        state_nxt    = state;
        reveal_nxt   = reveal;
        matched_nxt  = matched;
        first_nxt    = first_tile;
        attempts_nxt = attempts;
        timer_nxt    = timer;

        case (state)
            ST_IDLE: begin
                if (press) begin
                    state_nxt    = ST_PICK1;
                    matched_nxt  = 4'h0;
                    reveal_nxt   = 4'h0;
                    attempts_nxt = '0;
                end
            end

            ST_PICK1: begin
                if (press && !sel_matched) begin
                    first_nxt  = tile_sel;
                    reveal_nxt = reveal | sel_bit;
                    state_nxt  = ST_PICK2;
                end
            end

            ST_PICK2: begin
                if (press && (tile_sel != first_tile) && !sel_matched) begin
                    reveal_nxt = reveal | sel_bit;
                    timer_nxt  = TMR_LOAD;
                    if (attempts != ATT_MAX) begin
                        attempts_nxt = attempts + ATTEMPT_W'(1);
                    end
                    // Pairs are 0-3 and 1-2: complementary 2-bit indices.
                    if ((tile_sel ^ first_tile) == 2'b11) begin
                        matched_nxt = matched | sel_bit | first_bit;
                        state_nxt   = ST_HIT;
                    end else begin
                        state_nxt   = ST_MISS;
                    end
                end
            end

            ST_HIT: begin
                if (timer == '0) begin
                    if (matched == 4'hF) begin
                        state_nxt  = ST_WIN;
                        reveal_nxt = 4'hF;
                    end else begin
                        state_nxt  = ST_PICK1;
                    end
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            ST_MISS: begin
                if (timer == '0) begin
                    // Hide the two unmatched picks again.
                    reveal_nxt = matched;
                    state_nxt  = ST_PICK1;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            ST_WIN: begin
                reveal_nxt = 4'hF;
                if (press) begin
                    state_nxt   = ST_IDLE;
                    matched_nxt = 4'h0;
                    reveal_nxt  = 4'h0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ST_HIT) || (state_nxt == ST_MISS);
        win_nxt  = (state_nxt == ST_WIN);
    end

    // ------------------------------------------------------------------
    // Round FSM: state and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            reveal     <= 4'h0;
            matched    <= 4'h0;
            first_tile <= 2'd0;
            attempts   <= '0;
            timer      <= '0;
            busy       <= 1'b0;
            win        <= 1'b0;
        end else begin
            state      <= state_nxt;
            reveal     <= reveal_nxt;
            matched    <= matched_nxt;
            first_tile <= first_nxt;
            attempts   <= attempts_nxt;
            timer      <= timer_nxt;
            busy       <= busy_nxt;
            win        <= win_nxt;
        end
    end

    assign step = state;

endmodule

// File: tb/tb_match_round_ctrl.sv
// tb_match_round_ctrl: directed vectors plus hand sequences for match_round_ctrl
// with DB_CYCLES=4 and REVEAL_CYCLES=8.
module tb_match_round_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_raw;
    logic [1:0] tile_sel;
    logic [2:0] step;
    logic [3:0] reveal;
    logic [3:0] matched;
    logic [1:0] first_tile;
    logic [7:0] attempts;
    logic       busy;
    logic       win;

    int n_vec = 0;
    int n_err = 0;

    match_round_ctrl #(
        .DB_CYCLES    (4),
        .REVEAL_CYCLES(8),
        .ATTEMPT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .tile_sel  (tile_sel),
        .step      (step),
        .reveal    (reveal),
        .matched   (matched),
        .first_tile(first_tile),
        .attempts  (attempts),
        .busy      (busy),
        .win       (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] step;
        logic [3:0] rev;
        logic [3:0] mat;
        logic [1:0] first;
        logic [7:0] att;
        logic       busy;
        logic       win;
    } exp_t;

    typedef struct {
        logic [1:0] tile;
        exp_t       a;   // right after the press takes effect
        exp_t       b;   // 10 cycles later (any hit/miss display has finished)
    } vec_t;

    function automatic exp_t mk(input logic [2:0] s, input logic [3:0] r, input logic [3:0] m,
                                input logic [1:0] f, input logic [7:0] at, input logic bz,
                                input logic w);
        exp_t e;
        e.step = s; e.rev = r; e.mat = m; e.first = f; e.att = at; e.busy = bz; e.win = w;
        return e;
    endfunction

    task automatic chk(input string name, input exp_t e);
        exp_t a;
        a = mk(step, reveal, matched, first_tile, attempts, busy, win);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got step=%0d reveal=%b matched=%b first=%0d attempts=%0d busy=%b win=%b; want step=%0d reveal=%b matched=%b first=%0d attempts=%0d busy=%b win=%b",
                     name, a.step, a.rev, a.mat, a.first, a.att, a.busy, a.win,
                     e.step, e.rev, e.mat, e.first, e.att, e.busy, e.win);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, want);
        end
    endtask

    // Raise the button; returns 1 time unit after the edge on which the press acts.
    task automatic do_press(input logic [1:0] t);
        @(negedge clk);
        tile_sel = t;
        btn_raw  = 1'b1;
        repeat (7) @(posedge clk);
        #1;
    endtask

    task automatic release_btn();
        btn_raw = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic tap(input logic [1:0] t);
        do_press(t);
        release_btn();
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{2'd3, mk(1, 4'b1001, 4'b1001, 0, 1, 0, 0), mk(1, 4'b1001, 4'b1001, 0, 1, 0, 0)};
        vecs[1] = '{2'd1, mk(2, 4'b1011, 4'b1001, 1, 1, 0, 0), mk(2, 4'b1011, 4'b1001, 1, 1, 0, 0)};
        vecs[2] = '{2'd1, mk(2, 4'b1011, 4'b1001, 1, 1, 0, 0), mk(2, 4'b1011, 4'b1001, 1, 1, 0, 0)};
        vecs[3] = '{2'd2, mk(3, 4'b1111, 4'b1111, 1, 2, 1, 0), mk(6, 4'b1111, 4'b1111, 1, 2, 0, 1)};
        vecs[4] = '{2'd0, mk(0, 4'b0000, 4'b0000, 1, 2, 0, 0), mk(0, 4'b0000, 4'b0000, 1, 2, 0, 0)};
        vecs[5] = '{2'd1, mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0), mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0)};
        vecs[6] = '{2'd1, mk(2, 4'b0010, 4'b0000, 1, 0, 0, 0), mk(2, 4'b0010, 4'b0000, 1, 0, 0, 0)};
        vecs[7] = '{2'd3, mk(4, 4'b1010, 4'b0000, 1, 1, 1, 0), mk(1, 4'b0000, 4'b0000, 1, 1, 0, 0)};
        vecs[8] = '{2'd2, mk(2, 4'b0100, 4'b0000, 2, 1, 0, 0), mk(2, 4'b0100, 4'b0000, 2, 1, 0, 0)};
        vecs[9] = '{2'd0, mk(4, 4'b0101, 4'b0000, 2, 2, 1, 0), mk(1, 4'b0000, 4'b0000, 2, 2, 0, 0)};

        rst_n    = 1'b0;
        btn_raw  = 1'b0;
        tile_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", mk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Clean press: pulse 6 edges after the rise, step moves on the 7th.
        @(negedge clk);
        btn_raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            chk_bit($sformatf("press_pulse_e%0d", e), dut.press, (e == 6));
            chk_bit($sformatf("step_idle_e%0d", e), (step == 3'd1), (e == 7));
        end
        release_btn();
        chk("first_press", mk(1, 0, 0, 0, 0, 0, 0));

        // Pick 0 then 3: hit, displayed for exactly 8 cycles.
        tap(2'd0);
        chk("pick0", mk(2, 4'b0001, 0, 0, 0, 0, 0));
        do_press(2'd3);
        chk("hit03", mk(3, 4'b1001, 4'b1001, 0, 1, 1, 0));
        btn_raw = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hit_dwell_%0d", c), mk(3, 4'b1001, 4'b1001, 0, 1, 1, 0));
        end
        @(posedge clk);
        #1;
        chk("hit_done", mk(1, 4'b1001, 4'b1001, 0, 1, 0, 0));

        // Table: ignored presses, second hit to win, restart, misses.
        foreach (vecs[i]) begin
            do_press(vecs[i].tile);
            chk($sformatf("vec%0d_a", i), vecs[i].a);
            release_btn();
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_b", i), vecs[i].b);
        end

        // Press arriving during a miss is dropped and has no later effect.
        tap(2'd1);
        chk("pick1_again", mk(2, 4'b0010, 0, 1, 2, 0, 0));
        do_press(2'd0);
        chk("miss10", mk(4, 4'b0011, 0, 1, 3, 1, 0));
        btn_raw = 1'b0;
        tile_sel = 2'd2;
        force dut.press = 1'b1;
        @(posedge clk);
        #1;
        release dut.press;
        chk("miss_press_dropped", mk(4, 4'b0011, 0, 1, 3, 1, 0));
        repeat (7) @(posedge clk);
        #1;
        chk("miss_done", mk(1, 0, 0, 1, 3, 0, 0));
        repeat (10) @(posedge clk);
        #1;
        chk("miss_no_late_effect", mk(1, 0, 0, 1, 3, 0, 0));

        // 3-cycle glitch is rejected by the debouncer.
        @(negedge clk);
        btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        btn_raw = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("glitch", mk(1, 0, 0, 1, 3, 0, 0));

        // Asynchronous reset in the middle of a miss.
        tap(2'd2);
        chk("pick2_b", mk(2, 4'b0100, 0, 2, 3, 0, 0));
        do_press(2'd0);
        chk("miss20", mk(4, 4'b0101, 0, 2, 4, 1, 0));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", mk(0, 0, 0, 0, 0, 0, 0));
        btn_raw = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_idle", mk(0, 0, 0, 0, 0, 0, 0));
        tap(2'd3);
        chk("post_reset_press", mk(1, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
